// File: rtl/cla_seq_ctrl.sv
// rtl/cla_seq_ctrl.sv - two-client sequencer sharing an external 4-bit CLA slice
// Adds WIDTH-bit operands a nibble per cycle, LS nibble first, carry chained through a register.
module cla_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             req1_ready,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_sum,
  output logic             resp_cout,
  output logic             resp_id,
  output logic             busy,
  output logic [3:0]       slice_a,
  output logic [3:0]       slice_b,
  output logic             slice_cin,
  input  logic [3:0]       slice_s,
  input  logic             slice_cout
);

  localparam int NNIB = WIDTH / 4;
  localparam int KW   = (NNIB > 1) ? $clog2(NNIB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NNIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             rr_q, rr_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             id_q, id_d;

  logic             gnt_any;
  logic             gnt_id;
  logic             rdy0, rdy1;
  logic [KW+1:0]    nib_base;

  assign gnt_any  = req0_valid | req1_valid;
  assign gnt_id   = (req0_valid & req1_valid) ? rr_q : req1_valid;
  assign nib_base = {k_q, 2'b00};

  // State is already IDLE during reset, so the readys need explicit gating to stay low.
  assign req0_ready = Reset_n & rdy0;
  assign req1_ready = Reset_n & rdy1;
  assign busy       = (state_q != S_IDLE);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    k_d        = k_q;
    carry_d    = carry_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    id_d       = id_q;
    rdy0       = 1'b0;
    rdy1       = 1'b0;
    resp_valid = 1'b0;
    resp_sum   = '0;
    resp_cout  = 1'b0;
    resp_id    = 1'b0;
    slice_a    = 4'd0;
    slice_b    = 4'd0;
    slice_cin  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          rdy0    = ~gnt_id;
          rdy1    = gnt_id;
          a_d     = gnt_id ? req1_a   : req0_a;
          b_d     = gnt_id ? req1_b   : req0_b;
          carry_d = gnt_id ? req1_cin : req0_cin;
          id_d    = gnt_id;
          rr_d    = ~gnt_id;
          k_d     = '0;
          state_d = S_ADD;
        end
      end

      S_ADD: begin
        slice_a   = a_q[nib_base +: 4];
        slice_b   = b_q[nib_base +: 4];
        slice_cin = carry_q;
        sum_d[nib_base +: 4] = slice_s;
        carry_d   = slice_cout;
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = S_DONE;
        end else begin
          k_d     = k_q + KW'(1);
        end
      end

      S_DONE: begin
        resp_valid = 1'b1;
        resp_sum   = sum_q;
        resp_cout  = carry_q;
        resp_id    = id_q;
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
